// File: rtl/fifo_fwft_flags.sv
`default_nettype none
// ============================================================================
// Module   : fifo_fwft_flags
// Brief    : Single-clock FIFO with FWFT or registered-read output stage,
//            programmable almost flags, occupancy count and sticky errors.
// Revision : 1.0
// ============================================================================
module fifo_fwft_flags #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 4,
    parameter bit FWFT        = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    output logic                   full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   cnt,
    input  logic [DEPTH_WIDTH:0]   af_thresh,
    input  logic [DEPTH_WIDTH:0]   ae_thresh,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);

    localparam logic [DEPTH_WIDTH:0]   c_depth   = (DEPTH_WIDTH+1)'(2**DEPTH_WIDTH);
    localparam logic [DEPTH_WIDTH:0]   c_cnt_one = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] c_ptr_one = DEPTH_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  r_mem [2**DEPTH_WIDTH];
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [DEPTH_WIDTH:0]   r_cnt;
    logic                   r_full;
    logic                   r_empty;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_ovf;
    logic                   r_unf;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [DEPTH_WIDTH:0]   w_cnt_nxt;
    logic [DEPTH_WIDTH-1:0] w_rd_ptr_nxt;

    assign w_wr_acc     = wr_en && !r_full;
    assign w_rd_acc     = rd_en && !r_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_cnt - c_cnt_one;
        end
    end

    // Storage holds every word still counted, including the one shown on dout.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == c_depth);
            r_ovf  <= (wr_en && r_full)  || (r_ovf && !err_clr);
            r_unf  <= (rd_en && r_empty) || (r_unf && !err_clr);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // A stored word is presented one edge after it lands in an idle output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout  <= '0;
                    r_empty <= 1'b1;
                end else if (r_empty) begin
                    if (r_cnt != '0) begin
                        r_dout  <= r_mem[r_rd_ptr];
                        r_empty <= 1'b0;
                    end
                end else if (w_rd_acc) begin
                    if (r_cnt > c_cnt_one) begin
                        r_dout <= r_mem[w_rd_ptr_nxt];
                    end else begin
                        r_empty <= 1'b1;
                    end
                end
            end
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout  <= '0;
                    r_empty <= 1'b1;
                end else begin
                    r_empty <= (w_cnt_nxt == '0);
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign dout         = r_dout;
    assign cnt          = r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign almost_full  = (r_cnt >= af_thresh);
    assign almost_empty = (r_cnt <= ae_thresh);

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_fwft_flags
// Brief    : Self-checking bench for fifo_fwft_flags in FWFT and standard mode.
// Revision : 1.0
// ============================================================================
module tb_fifo_fwft_flags;

    localparam int c_depth = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [4:0] af_thresh, ae_thresh;
    logic       err_clr;
    logic       wr_f, rd_f, wr_s, rd_s;

    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic [7:0] dout_f, dout_s;
    logic [4:0] cnt_f, cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_fwft_flags #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_f), .full(full_f),
        .rd_en(rd_f), .dout(dout_f), .empty(empty_f), .cnt(cnt_f),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(af_f),
        .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f), .err_clr(err_clr)
    );

    fifo_fwft_flags #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_s), .full(full_s),
        .rd_en(rd_s), .dout(dout_s), .empty(empty_s), .cnt(cnt_s),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(af_s),
        .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s), .err_clr(err_clr)
    );

    // Reference model: index 0 is the FWFT instance, index 1 the standard one.
    logic [7:0] qf [$];
    logic [7:0] qs [$];
    bit         m_empty [2];
    logic [7:0] m_dout  [2];
    bit         m_ovf   [2];
    bit         m_unf   [2];

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] d;
        logic [4:0] cnt;
        bit         empty;
        logic [7:0] dout;
        bit         unf;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qf.delete();
        qs.delete();
        for (int i = 0; i < 2; i++) begin
            m_empty[i] = 1'b1;
            m_dout[i]  = 8'h00;
            m_ovf[i]   = 1'b0;
            m_unf[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int i, input bit wr, input bit rd, input logic [7:0] d);
        int n;
        bit was_full, wacc, racc;
        n        = (i == 0) ? qf.size() : qs.size();
        was_full = (n == c_depth);
        wacc     = wr && !was_full;
        racc     = rd && !m_empty[i];
        if (wr && was_full)        m_ovf[i] = 1'b1;
        else if (err_clr)          m_ovf[i] = 1'b0;
        if (rd && m_empty[i])      m_unf[i] = 1'b1;
        else if (err_clr)          m_unf[i] = 1'b0;
        if (i == 0) begin
            if (m_empty[0]) begin
                if (qf.size() > 0) begin
                    m_dout[0]  = qf[0];
                    m_empty[0] = 1'b0;
                end
            end else if (racc) begin
                void'(qf.pop_front());
                if (qf.size() > 0) m_dout[0] = qf[0];
                else               m_empty[0] = 1'b1;
            end
            if (wacc) qf.push_back(d);
        end else begin
            if (racc) m_dout[1] = qs.pop_front();
            if (wacc) qs.push_back(d);
            m_empty[1] = (qs.size() == 0);
        end
    endtask

    task automatic check_all();
        chk("f.cnt",   32'(cnt_f),   32'(qf.size()));
        chk("f.empty", 32'(empty_f), 32'(m_empty[0]));
        chk("f.full",  32'(full_f),  32'(qf.size() == c_depth));
        chk("f.dout",  32'(dout_f),  32'(m_dout[0]));
        chk("f.af",    32'(af_f),    32'(qf.size() >= int'(af_thresh)));
        chk("f.ae",    32'(ae_f),    32'(qf.size() <= int'(ae_thresh)));
        chk("f.ovf",   32'(ovf_f),   32'(m_ovf[0]));
        chk("f.unf",   32'(unf_f),   32'(m_unf[0]));
        chk("s.cnt",   32'(cnt_s),   32'(qs.size()));
        chk("s.empty", 32'(empty_s), 32'(m_empty[1]));
        chk("s.full",  32'(full_s),  32'(qs.size() == c_depth));
        chk("s.dout",  32'(dout_s),  32'(m_dout[1]));
        chk("s.af",    32'(af_s),    32'(qs.size() >= int'(af_thresh)));
        chk("s.ae",    32'(ae_s),    32'(qs.size() <= int'(ae_thresh)));
        chk("s.ovf",   32'(ovf_s),   32'(m_ovf[1]));
        chk("s.unf",   32'(unf_s),   32'(m_unf[1]));
    endtask

    task automatic cyc(input bit wf, input bit rf, input bit ws, input bit rs,
                       input logic [7:0] d, input bit clr);
        wr_f = wf; rd_f = rf; wr_s = ws; rd_s = rs; din = d; err_clr = clr;
        @(posedge clk);
        model_edge(0, wr_f, rd_f, din);
        model_edge(1, wr_s, rd_s, din);
        #1;
        check_all();
        wr_f = 1'b0; rd_f = 1'b0; wr_s = 1'b0; rd_s = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int         got;
        int         n;
        bit         acc;
        logic [7:0] prev;

        vt[0] = '{1'b1, 1'b0, 8'hA5, 5'd1, 1'b1, 8'h00, 1'b0};
        vt[1] = '{1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'hA5, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'hA5, 1'b0};
        vt[3] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'hA5, 1'b1};
        vt[4] = '{1'b1, 1'b0, 8'h3C, 5'd1, 1'b1, 8'hA5, 1'b1};
        vt[5] = '{1'b1, 1'b0, 8'h7E, 5'd2, 1'b0, 8'h3C, 1'b1};
        vt[6] = '{1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 8'h7E, 1'b1};
        vt[7] = '{1'b1, 1'b1, 8'h11, 5'd1, 1'b1, 8'h7E, 1'b1};
        vt[8] = '{1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'h11, 1'b1};
        vt[9] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'h11, 1'b1};

        rst_n = 1'b0; din = 8'h00; err_clr = 1'b0;
        wr_f = 1'b0; rd_f = 1'b0; wr_s = 1'b0; rd_s = 1'b0;
        af_thresh = 5'd12; ae_thresh = 5'd3;
        model_reset();
        #12;
        check_all();
        af_thresh = 5'd0;
        #1;
        chk("rst.af_thresh0", 32'(af_f), 32'd1);
        af_thresh = 5'd12;
        #1;
        @(negedge clk);
        rst_n = 1'b1;

        // Single-word FWFT latency and pop/push interplay
        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].wr, vt[i].rd, 1'b0, 1'b0, vt[i].d, 1'b0);
            chk($sformatf("tbl%0d.cnt", i),   32'(cnt_f),   32'(vt[i].cnt));
            chk($sformatf("tbl%0d.empty", i), 32'(empty_f), 32'(vt[i].empty));
            chk($sformatf("tbl%0d.dout", i),  32'(dout_f),  32'(vt[i].dout));
            chk($sformatf("tbl%0d.unf", i),   32'(unf_f),   32'(vt[i].unf));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr.unf", 32'(unf_f), 32'd0);

        // Fill, overflow, simultaneous access while full, ordered drain
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i), 1'b0);
        chk("fill.full", 32'(full_f), 32'd1);
        chk("fill.cnt",  32'(cnt_f),  32'd16);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        chk("ovf.set", 32'(ovf_f), 32'd1);
        chk("ovf.cnt", 32'(cnt_f), 32'd16);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf.clr", 32'(ovf_f), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);
        chk("wrrd_full.cnt",  32'(cnt_f),  32'd15);
        chk("wrrd_full.ovf",  32'(ovf_f),  32'd1);
        chk("wrrd_full.dout", 32'(dout_f), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrrd_full.clr", 32'(ovf_f), 32'd0);
        got = 0;
        for (int k = 0; k < 40 && !(empty_f && cnt_f == 5'd0); k++) begin
            if (!empty_f) begin
                chk($sformatf("drain%0d", got), 32'(dout_f), 32'(got + 1));
                got++;
            end
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        chk("drain.count", 32'(got), 32'd15);

        // Threshold flags, including a threshold change mid-cycle
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
        chk("thr.af12_at8", 32'(af_f), 32'd0);
        af_thresh = 5'd5;
        #1;
        chk("thr.af5_at8", 32'(af_f), 32'd1);
        check_all();
        af_thresh = 5'd12;
        #1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h50 + i), 1'b0);
        chk("thr.af_at16", 32'(af_f), 32'd1);
        chk("thr.ae_at16", 32'(ae_f), 32'd0);

        // Random interleaved traffic on both instances, crossing pointer wrap
        for (int i = 0; i < 260; i++) begin
            int unsigned pw;
            pw   = (i < 90) ? 70 : (i < 170) ? 30 : 50;
            prev = dout_s;
            wr_s = ($urandom_range(99) < pw);
            rd_s = ($urandom_range(99) >= pw);
            acc  = rd_s && !empty_s;
            cyc(($urandom_range(99) < pw), ($urandom_range(99) >= pw), wr_s, rd_s,
                8'($urandom_range(255)), ($urandom_range(99) < 5));
            if (!acc) chk("s.dout_hold", 32'(dout_s), 32'(prev));
        end

        // Standard-mode underflow on an empty FIFO
        n = 0;
        while (!empty_s && n < 40) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            n++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("s.unf_clr", 32'(unf_s), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("s.unf_set", 32'(unf_s), 32'd1);

        // Asynchronous reset mid-burst
        n = 0;
        while (cnt_f != 5'd0 && n < 40) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        chk("arst.pre_cnt", 32'(cnt_f), 32'd9);
        wr_f = 1'b1; wr_s = 1'b1; din = 8'hC3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.f.cnt",   32'(cnt_f),   32'd0);
        chk("arst.f.empty", 32'(empty_f), 32'd1);
        chk("arst.f.full",  32'(full_f),  32'd0);
        chk("arst.f.dout",  32'(dout_f),  32'd0);
        chk("arst.s.cnt",   32'(cnt_s),   32'd0);
        chk("arst.s.dout",  32'(dout_s),  32'd0);
        wr_f = 1'b0; wr_s = 1'b0;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
